// File: rtl/mau_pkg.sv
// Shared types, funct3 encodings and request-decode helpers for the memory access unit.
package mau_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [15:0] MEM_BASE_DEFAULT = 16'h1000;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } mau_state_e;

  function automatic logic f3_illegal(input logic write, input logic [2:0] f3);
    if (write) return f3 > F3_W;
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

  // Size lives in funct3[1:0]: 00 byte, 01 half, 10 word.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b01:   return off[0];
      2'b10:   return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] store_mask(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_B:    return 4'b0001 << off;
      F3_H:    return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wdata);
    case (f3)
      F3_B:    return {4{wdata[7:0]}};
      F3_H:    return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response and data-memory port bundle of the memory access unit.
interface mem_access_unit_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        rsp_valid;
  logic        rsp_error;
  logic [31:0] rsp_rdata;

  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_wrdata;
  logic [3:0]  mem_wrbits;
  logic [31:0] mem_rddata;

  // Environment side: the requesting core plus the memory.
  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rddata,
    input  req_ready, rsp_valid, rsp_error, rsp_rdata,
    input  mem_address, mem_read, mem_write, mem_wrdata, mem_wrbits
  );

  // Unit side.
  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rddata,
    output req_ready, rsp_valid, rsp_error, rsp_rdata,
    output mem_address, mem_read, mem_write, mem_wrdata, mem_wrbits
  );

endinterface

// File: rtl/mau_load_align.sv
// Combinational load-data lane extraction with sign/zero extension.
module mau_load_align
  import mau_pkg::*;
(
  input  logic [31:0] rddata,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = rddata[{off, 3'b000} +: 8];
    half_v = off[1] ? rddata[31:16] : rddata[15:0];
    case (funct3)
      F3_B:    data = {{24{byte_v[7]}}, byte_v};
      F3_BU:   data = {24'h0, byte_v};
      F3_H:    data = {{16{half_v[15]}}, half_v};
      F3_HU:   data = {16'h0, half_v};
      default: data = rddata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator for the 64 KiB data memory; one request in flight at a time.
// Optional MAU_RANGE_CHECK_EN rejects requests whose addr[31:16] differs from MEM_BASE.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter logic [15:0] MEM_BASE = MEM_BASE_DEFAULT
) (
  input logic               clock,
  input logic               reset,
  mem_access_unit_if.slave  bus
);

  mau_state_e  state_q, state_d;
  logic        write_q, write_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  off_q, off_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_error_q, rsp_error_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic [31:0] mem_address_q, mem_address_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;
  logic [31:0] mem_wrdata_q, mem_wrdata_d;
  logic [3:0]  mem_wrbits_q, mem_wrbits_d;

  logic        range_err;
  logic        req_err;
  logic [31:0] load_data;

`ifdef MAU_RANGE_CHECK_EN
  assign range_err = bus.req_addr[31:16] != MEM_BASE;
`else
  logic unused_base;
  assign unused_base = ^MEM_BASE;
  assign range_err   = 1'b0;
`endif

  assign req_err = f3_illegal(bus.req_write, bus.req_funct3) ||
                   misaligned(bus.req_funct3, bus.req_addr[1:0]) || range_err;

  assign bus.req_ready   = (state_q == StIdle) && !reset;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_error   = rsp_error_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.mem_address = mem_address_q;
  assign bus.mem_read    = mem_read_q;
  assign bus.mem_write   = mem_write_q;
  assign bus.mem_wrdata  = mem_wrdata_q;
  assign bus.mem_wrbits  = mem_wrbits_q;

  mau_load_align u_load_align (
    .rddata (bus.mem_rddata),
    .off    (off_q),
    .funct3 (funct3_q),
    .data   (load_data)
  );

  always_comb begin
    state_d       = state_q;
    write_d       = write_q;
    funct3_d      = funct3_q;
    off_d         = off_q;
    rsp_valid_d   = 1'b0;
    rsp_error_d   = 1'b0;
    rsp_rdata_d   = 32'h0;
    mem_address_d = mem_address_q;
    mem_wrdata_d  = mem_wrdata_q;
    mem_read_d    = 1'b0;
    mem_write_d   = 1'b0;
    mem_wrbits_d  = 4'b0000;

    unique case (state_q)
      StIdle: begin
        if (bus.req_valid && bus.req_ready) begin
          write_d  = bus.req_write;
          funct3_d = bus.req_funct3;
          off_d    = bus.req_addr[1:0];
          if (req_err) begin
            state_d     = StResp;
            rsp_valid_d = 1'b1;
            rsp_error_d = 1'b1;
          end else begin
            // Memory signals are registered here so they appear exactly in ISSUE.
            state_d       = StIssue;
            mem_address_d = {bus.req_addr[31:2], 2'b00};
            mem_read_d    = !bus.req_write;
            mem_write_d   = bus.req_write;
            if (bus.req_write) begin
              mem_wrbits_d = store_mask(bus.req_funct3, bus.req_addr[1:0]);
              mem_wrdata_d = store_data(bus.req_funct3, bus.req_wdata);
            end
          end
        end
      end
      StIssue: begin
        if (write_q) begin
          state_d     = StResp;
          rsp_valid_d = 1'b1;
        end else begin
          state_d = StWait;
        end
      end
      StWait: begin
        state_d     = StResp;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = load_data;
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= StIdle;
      write_q       <= 1'b0;
      funct3_q      <= 3'b000;
      off_q         <= 2'b00;
      rsp_valid_q   <= 1'b0;
      rsp_error_q   <= 1'b0;
      rsp_rdata_q   <= 32'h0;
      mem_address_q <= 32'h0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_wrdata_q  <= 32'h0;
      mem_wrbits_q  <= 4'b0000;
    end else begin
      state_q       <= state_d;
      write_q       <= write_d;
      funct3_q      <= funct3_d;
      off_q         <= off_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_error_q   <= rsp_error_d;
      rsp_rdata_q   <= rsp_rdata_d;
      mem_address_q <= mem_address_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_wrdata_q  <= mem_wrdata_d;
      mem_wrbits_q  <= mem_wrbits_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit with a registered-read memory model.
module tb_mem_access_unit;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  mem_access_unit_if bus();

  mem_access_unit #(.MEM_BASE(16'h1000)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Memory model: writes and registered reads on the rising edge, independent of unit reset.
  logic [31:0] mem [0:16383];
  always @(posedge clock) begin
    if (bus.mem_write) begin
      for (int b = 0; b < 4; b++)
        if (bus.mem_wrbits[b]) mem[bus.mem_address[15:2]][8*b +: 8] <= bus.mem_wrdata[8*b +: 8];
    end
    if (bus.mem_read) bus.mem_rddata <= mem[bus.mem_address[15:2]];
  end

  logic [31:0] wr_addr, wr_data;
  logic [3:0]  wr_bits;
  int          rsp_cnt = 0;
  always @(negedge clock) begin
    if (bus.mem_write) begin
      wr_addr <= bus.mem_address;
      wr_data <= bus.mem_wrdata;
      wr_bits <= bus.mem_wrbits;
    end
    if (bus.rsp_valid) rsp_cnt <= rsp_cnt + 1;
  end

  int          lat, mcyc;
  logic        err, rdy_busy;
  logic [31:0] rd;

  // Issues one request; reports response latency (0 = none), error, data, first memory-strobe
  // cycle and whether req_ready was seen high before the response.
  task automatic do_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d);
    lat = 0; err = 1'b0; rd = 32'h0; mcyc = 0; rdy_busy = 1'b0;
    @(negedge clock);
    bus.req_valid = 1'b1; bus.req_write = w; bus.req_funct3 = f3;
    bus.req_addr = a; bus.req_wdata = d;
    for (int i = 0; i < 8 && !bus.req_ready; i++) @(negedge clock);
    @(posedge clock);
    #1 bus.req_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clock);
      if ((bus.mem_read || bus.mem_write) && mcyc == 0) mcyc = c;
      if (bus.rsp_valid) begin
        lat = c; err = bus.rsp_error; rd = bus.rsp_rdata;
        break;
      end
      if (bus.req_ready) rdy_busy = 1'b1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_funct3 = 3'b010;
    bus.req_addr = 32'h1000_0000; bus.req_wdata = 32'h0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    n_checks++; if (bus.req_ready !== 1'b0) $display("FAIL reset_ready got %b want 0", bus.req_ready); else n_pass++;
    n_checks++; if ({bus.rsp_valid, bus.rsp_error, bus.mem_read, bus.mem_write} !== 4'b0000)
      $display("FAIL reset_ctrl got %b want 0000", {bus.rsp_valid, bus.rsp_error, bus.mem_read, bus.mem_write});
    else n_pass++;
    n_checks++; if ({bus.mem_wrbits, bus.mem_address, bus.mem_wrdata, bus.rsp_rdata} !== 100'h0)
      $display("FAIL reset_data got %h/%h/%h/%h want 0", bus.mem_wrbits, bus.mem_address,
               bus.mem_wrdata, bus.rsp_rdata);
    else n_pass++;
    bus.req_valid = 1'b0;
    reset = 1'b0;
    @(negedge clock);
    n_checks++; if (bus.req_ready !== 1'b1) $display("FAIL ready_after_reset got %b want 1", bus.req_ready); else n_pass++;
  endtask

  task automatic test_word;
    do_req(1'b1, 3'b010, 32'h1000_0010, 32'hDEAD_BEEF);
    n_checks++; if (lat !== 2 || err !== 1'b0) $display("FAIL sw_resp got lat=%0d err=%b want 2/0", lat, err); else n_pass++;
    n_checks++; if (mcyc !== 1) $display("FAIL sw_issue_cycle got %0d want 1", mcyc); else n_pass++;
    n_checks++; if (wr_bits !== 4'b1111 || wr_data !== 32'hDEAD_BEEF || wr_addr !== 32'h1000_0010)
      $display("FAIL sw_bus got %b %h %h want 1111 deadbeef 10000010", wr_bits, wr_data, wr_addr);
    else n_pass++;
    do_req(1'b0, 3'b010, 32'h1000_0010, 32'h0);
    n_checks++; if (lat !== 3 || rd !== 32'hDEAD_BEEF) $display("FAIL lw got lat=%0d %h want 3 deadbeef", lat, rd); else n_pass++;
    n_checks++; if (mcyc !== 1 || rdy_busy !== 1'b0) $display("FAIL lw_timing got mcyc=%0d busy=%b want 1/0", mcyc, rdy_busy); else n_pass++;
  endtask

  task automatic test_byte;
    do_req(1'b1, 3'b000, 32'h1000_0013, 32'h0000_0080);
    n_checks++; if (lat !== 2 || wr_bits !== 4'b1000 || wr_data !== 32'h8080_8080 || wr_addr !== 32'h1000_0010)
      $display("FAIL sb got lat=%0d %b %h %h want 2 1000 80808080 10000010", lat, wr_bits, wr_data, wr_addr);
    else n_pass++;
    do_req(1'b0, 3'b000, 32'h1000_0013, 32'h0);
    n_checks++; if (lat !== 3 || rd !== 32'hFFFF_FF80) $display("FAIL lb got lat=%0d %h want 3 ffffff80", lat, rd); else n_pass++;
    do_req(1'b0, 3'b100, 32'h1000_0013, 32'h0);
    n_checks++; if (rd !== 32'h0000_0080) $display("FAIL lbu got %h want 00000080", rd); else n_pass++;
    do_req(1'b0, 3'b000, 32'h1000_0011, 32'h0);
    n_checks++; if (rd !== 32'hFFFF_FFBE) $display("FAIL lb_off1 got %h want ffffffbe", rd); else n_pass++;
  endtask

  task automatic test_half;
    do_req(1'b1, 3'b001, 32'h1000_0022, 32'h0000_8001);
    n_checks++; if (lat !== 2 || wr_bits !== 4'b1100 || wr_data !== 32'h8001_8001)
      $display("FAIL sh got lat=%0d %b %h want 2 1100 80018001", lat, wr_bits, wr_data);
    else n_pass++;
    do_req(1'b0, 3'b001, 32'h1000_0022, 32'h0);
    n_checks++; if (rd !== 32'hFFFF_8001) $display("FAIL lh got %h want ffff8001", rd); else n_pass++;
    do_req(1'b0, 3'b101, 32'h1000_0022, 32'h0);
    n_checks++; if (rd !== 32'h0000_8001) $display("FAIL lhu got %h want 00008001", rd); else n_pass++;
  endtask

  task automatic test_errors;
    do_req(1'b0, 3'b010, 32'h1000_0001, 32'h0);
    n_checks++; if (lat !== 1 || err !== 1'b1 || rd !== 32'h0 || mcyc !== 0)
      $display("FAIL lw_misaligned got lat=%0d err=%b rd=%h mcyc=%0d want 1 1 0 0", lat, err, rd, mcyc);
    else n_pass++;
    do_req(1'b0, 3'b001, 32'h1000_0023, 32'h0);
    n_checks++; if (lat !== 1 || err !== 1'b1 || mcyc !== 0) $display("FAIL lh_misaligned got lat=%0d err=%b mcyc=%0d want 1 1 0", lat, err, mcyc); else n_pass++;
    do_req(1'b1, 3'b011, 32'h1000_0030, 32'h1);
    n_checks++; if (lat !== 1 || err !== 1'b1 || mcyc !== 0) $display("FAIL st_f3_011 got lat=%0d err=%b mcyc=%0d want 1 1 0", lat, err, mcyc); else n_pass++;
    do_req(1'b1, 3'b100, 32'h1000_0030, 32'h1);
    n_checks++; if (lat !== 1 || err !== 1'b1) $display("FAIL st_f3_100 got lat=%0d err=%b want 1 1", lat, err); else n_pass++;
    do_req(1'b0, 3'b110, 32'h1000_0030, 32'h0);
    n_checks++; if (lat !== 1 || err !== 1'b1) $display("FAIL ld_f3_110 got lat=%0d err=%b want 1 1", lat, err); else n_pass++;
    do_req(1'b1, 3'b001, 32'h1000_0032, 32'h1);
    n_checks++; if (lat !== 2 || err !== 1'b0) $display("FAIL sh_aligned_hi got lat=%0d err=%b want 2 0", lat, err); else n_pass++;
  endtask

  task automatic test_range;
    do_req(1'b1, 3'b010, 32'h2000_0000, 32'h1234_5678);
`ifdef MAU_RANGE_CHECK_EN
    n_checks++; if (lat !== 1 || err !== 1'b1 || mcyc !== 0)
      $display("FAIL sw_out_of_range got lat=%0d err=%b mcyc=%0d want 1 1 0", lat, err, mcyc);
    else n_pass++;
`else
    n_checks++; if (lat !== 2 || err !== 1'b0 || mcyc !== 1)
      $display("FAIL sw_out_of_range got lat=%0d err=%b mcyc=%0d want 2 0 1", lat, err, mcyc);
    else n_pass++;
`endif
  endtask

  task automatic test_reset_issue;
    int cnt0;
    @(negedge clock);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_funct3 = 3'b010;
    bus.req_addr = 32'h1000_0040; bus.req_wdata = 32'hCAFE_F00D;
    @(posedge clock);
    #1 bus.req_valid = 1'b0;
    cnt0 = rsp_cnt;
    @(negedge clock);
    n_checks++; if (bus.mem_write !== 1'b1) $display("FAIL rst_issue_write got %b want 1", bus.mem_write); else n_pass++;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    n_checks++; if (bus.req_ready !== 1'b1) $display("FAIL rst_issue_ready got %b want 1", bus.req_ready); else n_pass++;
    repeat (3) @(negedge clock);
    n_checks++; if (rsp_cnt !== cnt0) $display("FAIL rst_issue_no_rsp got %0d want %0d", rsp_cnt, cnt0); else n_pass++;
    n_checks++; if (mem[16] !== 32'hCAFE_F00D) $display("FAIL rst_issue_mem got %h want cafef00d", mem[16]); else n_pass++;
    do_req(1'b0, 3'b010, 32'h1000_0040, 32'h0);
    n_checks++; if (lat !== 3 || rd !== 32'hCAFE_F00D) $display("FAIL rst_issue_readback got lat=%0d %h want 3 cafef00d", lat, rd); else n_pass++;
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_funct3 = 3'b000;
    bus.req_addr = 32'h0; bus.req_wdata = 32'h0; bus.mem_rddata = 32'h0;
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_errors();
    test_range();
    test_reset_issue();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
